// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the receiver state encoding, parity modes and the bit-period calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_t;

    // Truncating division: any fractional clock per bit is absorbed by mid-bit sampling.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser bringing the asynchronous serial line into the clk domain.
// Both flops reset to RESET_VALUE so an idle-high line produces no false start bit.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, glitch rejection, parity/framing/overrun
// reporting, and a one-entry valid/ready output buffer feeding the ALU operand logic.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    localparam uart_parity_t PAR_MODE = (PARITY == 1) ? PAR_EVEN :
                                        (PARITY == 2) ? PAR_ODD  : PAR_NONE;

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_param: CLOCK_FREQ/BAUD_RATE must give at least 4 clocks per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1..2");
    end

    logic line_s;

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (line_s)
    );

    uart_rx_state_t       state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 par_acc_q,    par_acc_d;
    logic                 par_err_q,    par_err_d;
    logic                 frm_err_q,    frm_err_d;
    logic [DATA_BITS-1:0] buf_data_q,   buf_data_d;
    logic                 buf_valid_q,  buf_valid_d;
    logic                 buf_perr_q,   buf_perr_d;
    logic                 buf_ferr_q,   buf_ferr_d;
    logic                 overrun_q,    overrun_d;
    logic                 busy_q,       busy_d;
    logic                 commit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        commit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!line_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    // A line that is high again at mid start bit was a glitch: drop silently.
                    if (!line_s) begin
                        state_d   = ST_DATA;
                        idx_d     = '0;
                        par_acc_d = 1'b0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {line_s, shift_q[DATA_BITS-1:1]};
                    par_acc_d = par_acc_q ^ line_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (PAR_MODE != PAR_NONE) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    idx_d     = '0;
                    par_err_d = ((par_acc_q ^ line_s) != (PAR_MODE == PAR_ODD));
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!line_s) begin
                        frm_err_d = 1'b1;
                    end
                    if (idx_q == STOP_LAST) begin
                        commit = 1'b1;
                        idx_d  = '0;
                        // A line still low here is a break; park until it releases.
                        if (line_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (line_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // The buffer may accept a new frame in the same cycle its old word is handed off.
    always_comb begin
        buf_data_d  = buf_data_q;
        buf_valid_d = buf_valid_q;
        buf_perr_d  = buf_perr_q;
        buf_ferr_d  = buf_ferr_q;
        overrun_d   = 1'b0;

        if (commit) begin
            if (!buf_valid_q || rx_ready) begin
                buf_data_d  = shift_q;
                buf_perr_d  = par_err_q;
                buf_ferr_d  = frm_err_q | ~line_s;
                buf_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (buf_valid_q && rx_ready) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_perr_q  <= 1'b0;
            buf_ferr_q  <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
            frm_err_q   <= frm_err_d;
            buf_data_q  <= buf_data_d;
            buf_valid_q <= buf_valid_d;
            buf_perr_q  <= buf_perr_d;
            buf_ferr_q  <= buf_ferr_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data       = buf_data_q;
    assign rx_valid      = buf_valid_q;
    assign rx_parity_err = buf_perr_q;
    assign rx_frame_err  = buf_ferr_q;
    assign rx_overrun    = overrun_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance (a) and an 8E1 instance (b),
// both at 10 clocks per bit, with expected values worked out by hand.
module tb_uart_rx_param;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       line_a  = 1'b1;
    logic       line_b  = 1'b1;
    logic       ready_a = 1'b1;
    logic       ready_b = 1'b1;

    logic [7:0] data_a, data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int lat       = 98;

    int         hs_a = 0, vcyc_a = 0, busy_cyc_a = 0, ovr_cnt_a = 0, last_hs_cyc_a = 0;
    logic [7:0] last_data_a = 8'h00;
    logic       last_perr_a = 1'b0, last_ferr_a = 1'b0;
    int         hs_b = 0, ovr_cnt_b = 0;
    logic [7:0] last_data_b = 8'h00;
    logic       last_perr_b = 1'b0, last_ferr_b = 1'b0;

    int h0, v0, b0, o0;

    uart_rx_param #(
        .CLOCK_FREQ (1000000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY     (0),
        .STOP_BITS  (1)
    ) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (line_a),
        .rx_data       (data_a),
        .rx_valid      (valid_a),
        .rx_ready      (ready_a),
        .rx_parity_err (perr_a),
        .rx_frame_err  (ferr_a),
        .rx_overrun    (ovr_a),
        .rx_busy       (busy_a)
    );

    uart_rx_param #(
        .CLOCK_FREQ (1000000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .PARITY     (1),
        .STOP_BITS  (1)
    ) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (line_b),
        .rx_data       (data_b),
        .rx_valid      (valid_b),
        .rx_ready      (ready_b),
        .rx_parity_err (perr_b),
        .rx_frame_err  (ferr_b),
        .rx_overrun    (ovr_b),
        .rx_busy       (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake and pulse monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_a) vcyc_a++;
        if (busy_a) busy_cyc_a++;
        if (ovr_a) ovr_cnt_a++;
        if (valid_a && ready_a) begin
            hs_a++;
            last_data_a   = data_a;
            last_perr_a   = perr_a;
            last_ferr_a   = ferr_a;
            last_hs_cyc_a = cyc;
        end
        if (ovr_b) ovr_cnt_b++;
        if (valid_b && ready_b) begin
            hs_b++;
            last_data_b = data_b;
            last_perr_b = perr_b;
            last_ferr_b = ferr_b;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setLine(input int which, input logic v);
        if (which == 0) line_a = v;
        else            line_b = v;
    endtask

    // Drives one frame, 10 clocks per bit; the start bit begins just after a rising edge.
    task automatic applyStimulus(input int which, input logic [7:0] data, input logic has_par,
                                 input logic par_bit, input logic stop_bit);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        setLine(which, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            setLine(which, data[i]);
            repeat (10) @(posedge clk);
            #1;
        end
        if (has_par) begin
            setLine(which, par_bit);
            repeat (10) @(posedge clk);
            #1;
        end
        setLine(which, stop_bit);
        repeat (10) @(posedge clk);
        #1;
        setLine(which, 1'b1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        settle(3);
        checkOutput("rst_valid", valid_a, 0);
        checkOutput("rst_data", data_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_overrun", ovr_a, 0);
        checkOutput("rst_errs", {perr_a, ferr_a}, 0);
        rst_n = 1'b1;
        settle(5);

        $display("[TB] test 1: 8N1 0xA5");
        h0 = hs_a; v0 = vcyc_a;
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        settle(5);
        lat = last_hs_cyc_a - start_cyc;
        checkOutput("t1_handshakes", hs_a - h0, 1);
        checkOutput("t1_data", last_data_a, 8'hA5);
        checkOutput("t1_perr", last_perr_a, 0);
        checkOutput("t1_ferr", last_ferr_a, 0);
        checkOutput("t1_valid_cycles", vcyc_a - v0, 1);
        checkOutput("t1_latency_97_99", (lat >= 97 && lat <= 99), 1);
        checkOutput("t1_busy_after", busy_a, 0);
        if (lat < 90 || lat > 110) lat = 98;

        $display("[TB] test 2: start glitch");
        h0 = hs_a; b0 = busy_cyc_a;
        @(posedge clk); #1 line_a = 1'b0;
        settle(3);
        line_a = 1'b1;
        settle(20);
        checkOutput("t2_no_handshake", hs_a - h0, 0);
        checkOutput("t2_busy_cycles", busy_cyc_a - b0, 5);
        checkOutput("t2_busy_low", busy_a, 0);
        checkOutput("t2_valid_low", valid_a, 0);

        $display("[TB] test 3: even parity");
        h0 = hs_b;
        applyStimulus(1, 8'h03, 1'b1, 1'b1, 1'b1);
        settle(5);
        checkOutput("t3_handshakes", hs_b - h0, 1);
        checkOutput("t3_bad_data", last_data_b, 8'h03);
        checkOutput("t3_bad_perr", last_perr_b, 1);
        checkOutput("t3_bad_ferr", last_ferr_b, 0);
        applyStimulus(1, 8'h03, 1'b1, 1'b0, 1'b1);
        settle(5);
        checkOutput("t3_good_data", last_data_b, 8'h03);
        checkOutput("t3_good_perr", last_perr_b, 0);

        $display("[TB] test 4: framing error and break");
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b0);
        settle(5);
        checkOutput("t4_data", last_data_a, 8'h55);
        checkOutput("t4_ferr", last_ferr_a, 1);
        checkOutput("t4_perr", last_perr_a, 0);
        h0 = hs_a;
        @(posedge clk); #1 line_a = 1'b0;
        settle(200);
        line_a = 1'b1;
        settle(20);
        checkOutput("t4_break_frames", hs_a - h0, 1);
        checkOutput("t4_break_data", last_data_a, 8'h00);
        checkOutput("t4_break_ferr", last_ferr_a, 1);
        checkOutput("t4_break_busy", busy_a, 0);
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        settle(5);
        checkOutput("t4_after_data", last_data_a, 8'h3C);
        checkOutput("t4_after_ferr", last_ferr_a, 0);

        $display("[TB] test 5: backpressure and overrun");
        ready_a = 1'b0;
        h0 = hs_a; o0 = ovr_cnt_a;
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
        settle(5);
        checkOutput("t5_first_valid", valid_a, 1);
        checkOutput("t5_first_data", data_a, 8'h11);
        applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
        settle(5);
        checkOutput("t5_hold_data", data_a, 8'h11);
        checkOutput("t5_hold_valid", valid_a, 1);
        checkOutput("t5_overrun_pulses", ovr_cnt_a - o0, 1);
        checkOutput("t5_no_handshake", hs_a - h0, 0);
        ready_a = 1'b1;
        settle(3);
        checkOutput("t5_drain_count", hs_a - h0, 1);
        checkOutput("t5_drain_data", last_data_a, 8'h11);
        checkOutput("t5_no_second", valid_a, 0);

        ready_a = 1'b0;
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
        settle(5);
        h0 = hs_a; o0 = ovr_cnt_a;
        fork
            applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        settle(5);
        checkOutput("t5_same_cycle_hs", hs_a - h0, 1);
        checkOutput("t5_same_cycle_old", last_data_a, 8'h11);
        checkOutput("t5_same_cycle_new", data_a, 8'h22);
        checkOutput("t5_same_cycle_valid", valid_a, 1);
        checkOutput("t5_same_cycle_no_ovr", ovr_cnt_a - o0, 0);
        ready_a = 1'b1;
        settle(3);
        checkOutput("t5_final_drain", last_data_a, 8'h22);

        $display("[TB] test 6: reset mid-frame");
        ready_a = 1'b0;
        applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        settle(5);
        checkOutput("t6_pre_valid", valid_a, 1);
        fork
            applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (55) @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                checkOutput("t6_rst_valid", valid_a, 0);
                checkOutput("t6_rst_data", data_a, 0);
                checkOutput("t6_rst_busy", busy_a, 0);
                checkOutput("t6_rst_flags", {perr_a, ferr_a, ovr_a}, 0);
            end
        join
        settle(5);
        rst_n   = 1'b1;
        ready_a = 1'b1;
        settle(5);
        h0 = hs_a;
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        settle(5);
        checkOutput("t6_after_count", hs_a - h0, 1);
        checkOutput("t6_after_data", last_data_a, 8'h3C);
        checkOutput("t6_after_flags", {last_perr_a, last_ferr_a}, 0);

        checkOutput("end_b_idle", busy_b, 0);
        checkOutput("end_b_no_overrun", ovr_cnt_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
